ahbl_splitter_burst: RTL and testbench
======================================

# ahbl_splitter_burst

AHB-lite 1:N splitter with burst-aware routing, for the Hazard3 example SoC bus fabric. Decodes each NONSEQ address to one downstream port and holds that selection for the SEQ and BUSY beats of the same burst. Issues a protocol-correct two-cycle ERROR response for unmapped or unconnected addresses. Replicates address, control and exclusive-access sideband signals to all ports, and muxes the data-phase response back to the master.

## Interface
- `N_PORTS`, 2, number of downstream ports (1..16)
- `W_ADDR`, 32, address width
- `W_DATA`, 32, data width
- `ADDR_MAP`, N_PORTS×W_ADDR, per-port base address; port i in slice `[i*W_ADDR +: W_ADDR]`
- `ADDR_MASK`, N_PORTS×W_ADDR, per-port compare mask; port i matches when `(haddr & MASK_i) == MAP_i`
- `CONN_MASK`, all ones, per-port connect enable; an address matching only masked ports is a decode error
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous and active-high
- `src_hready` in 1: bus hready as seen by the master; tie to `src_hready_resp` at the top of the fabric
- `src_hready_resp` out 1
- `src_hresp` out 1
- `src_haddr` in W_ADDR
- `src_hwrite` in 1
- `src_htrans` in 2
- `src_hsize` in 3
- `src_hburst` in 3
- `src_hprot` in 4
- `src_hmastlock` in 1
- `src_hexcl` in 1
- `src_hmaster` in 8
- `src_hwdata` in W_DATA
- `src_hrdata` out W_DATA
- `src_hexokay` out 1
- `dst_*`: the same signals per port, packed N_PORTS wide. Widths:
  - `dst_hready` out N
  - `dst_hready_resp` in N
  - `dst_hresp` in N
  - `dst_haddr` out N×W_ADDR
  - `dst_hwrite` out N
  - `dst_htrans` out 2N
  - `dst_hsize` out 3N
  - `dst_hburst` out 3N
  - `dst_hprot` out 4N
  - `dst_hmastlock` out N
  - `dst_hexcl` out N
  - `dst_hmaster` out 8N
  - `dst_hwdata` out N×W_DATA
  - `dst_hrdata` in N×W_DATA
  - `dst_hexokay` in N

## Operation
- **Address decode (combinational, NONSEQ only):**
  - `match[i]` is the mask/map compare for port i.
  - When several ports match, the lowest index wins (priority encode). The result is a one-hot `sel_a`.
  - Decode error is raised when there is no match, or when the winning port has `CONN_MASK=0`.
- **Burst hold:**
  - A NONSEQ accepted with `src_hready=1` latches `sel_a` and the error flag into `burst_sel` / `burst_err`.
  - SEQ and BUSY beats use `burst_sel` / `burst_err` and do not re-decode.
  - IDLE selects nothing.
  - A SEQ or BUSY arriving with no open burst (after reset or after IDLE) is treated as a decode error.
- **`dst_htrans`:** the selected port receives `src_htrans`, including BUSY. All other ports receive IDLE.
- **Replication:** all other address/control/sideband signals, plus `hwdata` and `hready`, are replicated unmasked.
- **Data-phase state:** `sel_d` and `err_d` load from the address-phase selection when `src_hready=1`.
  - IDLE and BUSY load `sel_d=0`, `err_d=0` and give a zero-wait OKAY.
- **Response mux:**
  - With `sel_d` one-hot, `hready_resp`, `hresp`, `hrdata` and `hexokay` come from that port.
  - When nothing is selected, `hrdata` is 0 and `hexokay` is 0.
- **Error FSM states:**
  - IDLE → ERR1 when `err_d` is set.
  - ERR1 outputs `hready_resp=0`, `hresp=1`, then goes to ERR2.
  - ERR2 outputs `hready_resp=1`, `hresp=1`, then returns to IDLE. If a new erroring transfer was accepted in ERR2, it goes to ERR1 instead.
- **Burst after ERROR:** a master that continues the burst after ERROR keeps `burst_err`, so every SEQ beat errors. A master that cancels with IDLE clears the burst.

## Timing
- Address-to-`dst_htrans` path is combinational.
- The response path depends only on data-phase registers: no combinational path from `src_htrans` or `src_haddr` to `src_hready_resp` or `src_hresp`.
- Zero added wait states for mapped transfers. An ERROR costs exactly 2 cycles.
- **Reset values:**
  - `sel_d=0`, `err_d=0`, `burst_sel=0`, `burst_err=0`, FSM=IDLE.
  - Outputs: `src_hready_resp=1`, `src_hresp=0`, `src_hrdata=0`, `src_hexokay=0`, `dst_htrans=IDLE`.
- `rst` asserted mid-transfer, including mid-ERROR, returns every register to reset values immediately.
- While `src_hready=0`, every register except the FSM holds.

## Structure
- Shared package `ahbl_pkg`:
  - HTRANS constants IDLE/BUSY/NONSEQ/SEQ.
  - HRESP OKAY/ERROR.
  - Error FSM state encoding.
- Response data path reuses the existing `onehot_mux`.
- One new sub-module, `ahbl_addr_decode`: mask/map compare, priority encode, CONN_MASK check, producing `sel_a` and `err_a`.

## Test plan
- **Mapped INCR4 read:** ports at 0x2000_0000 and 0x4000_0000 with mask 0xF000_0000. NONSEQ 0x4000_0000 then SEQ 0x4000_0004..0C → only `dst_htrans[3:2]` active; the 4 `hrdata` beats come from port 1; `src_hready_resp` is never low.
- **Decode error:** NONSEQ 0x8000_0000 → no `dst_htrans` active; next data cycle `hready_resp=0`/`hresp=1`, then `1`/`1`, then OKAY on a following IDLE.
- **Overlapping match:** port 0 mask 0, port 1 matching 0x4xxx_xxxx; access 0x4000_0000 → port 0 selected.
- **Unconnected port:** `CONN_MASK=2'b01`, access 0x4000_0000 → ERROR sequence, port 1 sees IDLE.
- **BUSY and wait states in a burst:** BUSY between SEQ beats, and `dst_hready_resp` low for 3 cycles on beat 2 → BUSY is forwarded to the burst port with a zero-wait OKAY; beat 2 stalls exactly 3 cycles; `hwdata` and `hexokay` pass through.
- **Reset during ERR1:** `rst` pulsed while in ERR1 → next cycle `hready_resp=1`, `hresp=0`, `sel_d=0`.

Source files
------------

// File: rtl/ahbl_pkg.sv
// Shared AHB-lite definitions: transfer types, response codes and the
// error-response state encoding used by the splitter fabric.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ERR_IDLE = 2'd0,
        ERR_ERR1 = 2'd1,
        ERR_ERR2 = 2'd2
    } err_state_e;

endpackage

// File: rtl/ahbl_addr_decode.sv
// Address decoder: mask/map compare per port, lowest-index priority, and a
// decode error for no match or a winning port that is not connected.
module ahbl_addr_decode
    import ahbl_pkg::*;
#(
    parameter int                        N_PORTS   = 2,
    parameter int                        W_ADDR    = 32,
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = '0,
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = '0,
    parameter logic [N_PORTS-1:0]        CONN_MASK = '1
) (
    input  logic [W_ADDR-1:0]  haddr,
    output logic [N_PORTS-1:0] sel_a,
    output logic               err_a
);

    logic [N_PORTS-1:0] match_s;
    logic [N_PORTS-1:0] win_s;

    // Per-port window compare
    always_comb begin
        match_s = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            match_s[i] = ((haddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) == ADDR_MAP[i*W_ADDR +: W_ADDR]);
        end
    end

    // Isolate the lowest set match bit (two's-complement trick)
    assign win_s = match_s & (~match_s + {{(N_PORTS-1){1'b0}}, 1'b1});

    assign err_a = ~(|(win_s & CONN_MASK));
    assign sel_a = err_a ? {N_PORTS{1'b0}} : win_s;

endmodule

// File: rtl/onehot_mux.sv
// OR-reduction multiplexer for a one-hot select; an all-zero select yields zero.
module onehot_mux #(
    parameter int N_INPUTS = 2,
    parameter int W_INPUT  = 32
) (
    input  logic [N_INPUTS*W_INPUT-1:0] data,
    input  logic [N_INPUTS-1:0]         sel,
    output logic [W_INPUT-1:0]          result
);

    // Gate each input by its select bit and OR everything together
    always_comb begin
        result = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (sel[i]) begin
                result = result | data[i*W_INPUT +: W_INPUT];
            end else begin
                result = result;
            end
        end
    end

endmodule

// File: rtl/ahbl_splitter_burst.sv
// AHB-lite 1:N splitter: decodes NONSEQ beats, holds the port for the rest of
// the burst, muxes the data-phase response and generates two-cycle ERRORs.
module ahbl_splitter_burst
    import ahbl_pkg::*;
#(
    parameter int                        N_PORTS   = 2,
    parameter int                        W_ADDR    = 32,
    parameter int                        W_DATA    = 32,
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = {32'h4000_0000, 32'h2000_0000},
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = {32'hf000_0000, 32'hf000_0000},
    parameter logic [N_PORTS-1:0]        CONN_MASK = '1
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        src_hready,
    output logic                        src_hready_resp,
    output logic                        src_hresp,
    input  logic [W_ADDR-1:0]           src_haddr,
    input  logic                        src_hwrite,
    input  logic [1:0]                  src_htrans,
    input  logic [2:0]                  src_hsize,
    input  logic [2:0]                  src_hburst,
    input  logic [3:0]                  src_hprot,
    input  logic                        src_hmastlock,
    input  logic                        src_hexcl,
    input  logic [7:0]                  src_hmaster,
    input  logic [W_DATA-1:0]           src_hwdata,
    output logic [W_DATA-1:0]           src_hrdata,
    output logic                        src_hexokay,

    output logic [N_PORTS-1:0]          dst_hready,
    input  logic [N_PORTS-1:0]          dst_hready_resp,
    input  logic [N_PORTS-1:0]          dst_hresp,
    output logic [N_PORTS*W_ADDR-1:0]   dst_haddr,
    output logic [N_PORTS-1:0]          dst_hwrite,
    output logic [N_PORTS*2-1:0]        dst_htrans,
    output logic [N_PORTS*3-1:0]        dst_hsize,
    output logic [N_PORTS*3-1:0]        dst_hburst,
    output logic [N_PORTS*4-1:0]        dst_hprot,
    output logic [N_PORTS-1:0]          dst_hmastlock,
    output logic [N_PORTS-1:0]          dst_hexcl,
    output logic [N_PORTS*8-1:0]        dst_hmaster,
    output logic [N_PORTS*W_DATA-1:0]   dst_hwdata,
    input  logic [N_PORTS*W_DATA-1:0]   dst_hrdata,
    input  logic [N_PORTS-1:0]          dst_hexokay
);

    logic [N_PORTS-1:0]   dec_sel_s;
    logic                 dec_err_s;
    logic [N_PORTS-1:0]   sel_a_s;
    logic                 err_a_s;
    logic [N_PORTS-1:0]   burst_sel_r;
    logic                 burst_err_r;
    logic [N_PORTS-1:0]   sel_d_r;
    logic                 err_d_r;
    logic                 load_err_s;
    err_state_e           state_r;
    err_state_e           state_s;
    logic [N_PORTS*3-1:0] resp_bus_s;
    logic [2:0]           resp_sel_s;

    ahbl_addr_decode #(
        .N_PORTS   (N_PORTS),
        .W_ADDR    (W_ADDR),
        .ADDR_MAP  (ADDR_MAP),
        .ADDR_MASK (ADDR_MASK),
        .CONN_MASK (CONN_MASK)
    ) u_decode (
        .haddr (src_haddr),
        .sel_a (dec_sel_s),
        .err_a (dec_err_s)
    );

    // Address-phase target: fresh decode on NONSEQ, burst hold on SEQ/BUSY
    always_comb begin
        sel_a_s = '0;
        err_a_s = 1'b0;
        case (src_htrans)
            HTRANS_NONSEQ: begin
                sel_a_s = dec_sel_s;
                err_a_s = dec_err_s;
            end
            HTRANS_SEQ, HTRANS_BUSY: begin
                sel_a_s = burst_sel_r;
                err_a_s = burst_err_r | (burst_sel_r == {N_PORTS{1'b0}});
            end
            default: begin
                sel_a_s = '0;
                err_a_s = 1'b0;
            end
        endcase
    end

    // Only the selected port sees the real transfer type
    always_comb begin
        dst_htrans = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (sel_a_s[i]) begin
                dst_htrans[2*i +: 2] = src_htrans;
            end else begin
                dst_htrans[2*i +: 2] = HTRANS_IDLE;
            end
        end
    end

    assign dst_hready    = {N_PORTS{src_hready}};
    assign dst_haddr     = {N_PORTS{src_haddr}};
    assign dst_hwrite    = {N_PORTS{src_hwrite}};
    assign dst_hsize     = {N_PORTS{src_hsize}};
    assign dst_hburst    = {N_PORTS{src_hburst}};
    assign dst_hprot     = {N_PORTS{src_hprot}};
    assign dst_hmastlock = {N_PORTS{src_hmastlock}};
    assign dst_hexcl     = {N_PORTS{src_hexcl}};
    assign dst_hmaster   = {N_PORTS{src_hmaster}};
    assign dst_hwdata    = {N_PORTS{src_hwdata}};

    // Burst and data-phase registers, advancing only on accepted beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_sel_r <= '0;
            burst_err_r <= 1'b0;
            sel_d_r     <= '0;
            err_d_r     <= 1'b0;
        end else if (src_hready) begin
            if (src_htrans == HTRANS_NONSEQ) begin
                burst_sel_r <= dec_sel_s;
                burst_err_r <= dec_err_s;
            end else if (src_htrans == HTRANS_IDLE) begin
                burst_sel_r <= '0;
                burst_err_r <= 1'b0;
            end else begin
                burst_sel_r <= burst_sel_r;
                burst_err_r <= burst_err_r;
            end
            sel_d_r <= src_htrans[1] ? sel_a_s : {N_PORTS{1'b0}};
            err_d_r <= src_htrans[1] & err_a_s;
        end else begin
            burst_sel_r <= burst_sel_r;
            burst_err_r <= burst_err_r;
            sel_d_r     <= sel_d_r;
            err_d_r     <= err_d_r;
        end
    end

    // ERR1 coincides with the first data cycle of an erroring transfer
    assign load_err_s = src_hready & src_htrans[1] & err_a_s;

    // Error response state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ERR_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Error response next-state
    always_comb begin
        state_s = state_r;
        case (state_r)
            ERR_IDLE: state_s = load_err_s ? ERR_ERR1 : ERR_IDLE;
            ERR_ERR1: state_s = err_d_r ? ERR_ERR2 : ERR_IDLE;
            ERR_ERR2: state_s = load_err_s ? ERR_ERR1 : ERR_IDLE;
            default:  state_s = ERR_IDLE;
        endcase
    end

    // Pack per-port handshake bits for the response mux
    always_comb begin
        resp_bus_s = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            resp_bus_s[3*i +: 3] = {dst_hready_resp[i], dst_hresp[i], dst_hexokay[i]};
        end
    end

    onehot_mux #(.N_INPUTS(N_PORTS), .W_INPUT(3)) u_resp_mux (
        .data   (resp_bus_s),
        .sel    (sel_d_r),
        .result (resp_sel_s)
    );

    onehot_mux #(.N_INPUTS(N_PORTS), .W_INPUT(W_DATA)) u_rdata_mux (
        .data   (dst_hrdata),
        .sel    (sel_d_r),
        .result (src_hrdata)
    );

    // Master-facing response from data-phase state only
    always_comb begin
        src_hready_resp = 1'b1;
        src_hresp       = HRESP_OKAY;
        case (state_r)
            ERR_ERR1: begin
                src_hready_resp = 1'b0;
                src_hresp       = HRESP_ERROR;
            end
            ERR_ERR2: begin
                src_hready_resp = 1'b1;
                src_hresp       = HRESP_ERROR;
            end
            default: begin
                if (|sel_d_r) begin
                    src_hready_resp = resp_sel_s[2];
                    src_hresp       = resp_sel_s[1];
                end else begin
                    src_hready_resp = 1'b1;
                    src_hresp       = HRESP_OKAY;
                end
            end
        endcase
    end

    assign src_hexokay = resp_sel_s[0];

endmodule

// File: tb/tb_ahbl_splitter_burst.sv
// Bench for ahbl_splitter_burst: three map configurations share one stimulus;
// instance 0 is compared every cycle against a transfer-level reference model.
module tb_ahbl_splitter_burst;
    import ahbl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic        hexcl;
    logic [7:0]  hmaster;
    logic [31:0] hwdata;
    logic [1:0]  d_hready_in;
    logic [1:0]  d_hresp_in;
    logic [1:0]  d_hexokay_in;
    logic [63:0] d_hrdata_in;

    logic        s_hready      [3];
    logic        o_hready_resp [3];
    logic        o_hresp       [3];
    logic        o_hexokay     [3];
    logic [31:0] o_hrdata      [3];
    logic [1:0]  o_dhready     [3];
    logic [63:0] o_dhaddr      [3];
    logic [1:0]  o_dhwrite     [3];
    logic [3:0]  o_dhtrans     [3];
    logic [5:0]  o_dhsize      [3];
    logic [5:0]  o_dhburst     [3];
    logic [7:0]  o_dhprot      [3];
    logic [1:0]  o_dhmastlock  [3];
    logic [1:0]  o_dhexcl      [3];
    logic [15:0] o_dhmaster    [3];
    logic [63:0] o_dhwdata     [3];

    // 0: ports at 0x2/0x4; 1: port 0 matches everything; 2: port 1 unconnected
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam logic [63:0] MAP = (g == 1) ? 64'h4000_0000_0000_0000 : 64'h4000_0000_2000_0000;
        localparam logic [63:0] MSK = (g == 1) ? 64'hf000_0000_0000_0000 : 64'hf000_0000_f000_0000;
        localparam logic [1:0]  CON = (g == 2) ? 2'b01 : 2'b11;
        assign s_hready[g] = o_hready_resp[g];
        ahbl_splitter_burst #(
            .N_PORTS(2), .W_ADDR(32), .W_DATA(32),
            .ADDR_MAP(MAP), .ADDR_MASK(MSK), .CONN_MASK(CON)
        ) u_dut (
            .clk(clk), .rst(rst),
            .src_hready(s_hready[g]), .src_hready_resp(o_hready_resp[g]), .src_hresp(o_hresp[g]),
            .src_haddr(haddr), .src_hwrite(hwrite), .src_htrans(htrans), .src_hsize(hsize),
            .src_hburst(hburst), .src_hprot(hprot), .src_hmastlock(hmastlock), .src_hexcl(hexcl),
            .src_hmaster(hmaster), .src_hwdata(hwdata), .src_hrdata(o_hrdata[g]), .src_hexokay(o_hexokay[g]),
            .dst_hready(o_dhready[g]), .dst_hready_resp(d_hready_in), .dst_hresp(d_hresp_in),
            .dst_haddr(o_dhaddr[g]), .dst_hwrite(o_dhwrite[g]), .dst_htrans(o_dhtrans[g]),
            .dst_hsize(o_dhsize[g]), .dst_hburst(o_dhburst[g]), .dst_hprot(o_dhprot[g]),
            .dst_hmastlock(o_dhmastlock[g]), .dst_hexcl(o_dhexcl[g]), .dst_hmaster(o_dhmaster[g]),
            .dst_hwdata(o_dhwdata[g]), .dst_hrdata(d_hrdata_in), .dst_hexokay(d_hexokay_in)
        );
    end

    int checks   = 0;
    int failures = 0;
    int m_burst;   // port owning the open burst, -1 when a SEQ/BUSY would error
    int m_dport;   // port answering the current data phase, -1 for none
    int m_err;     // 0: no error, 1/2: first/second ERROR cycle
    logic acc;

    function automatic int dec_port(input logic [31:0] a);
        if (a[31:28] == 4'h2) return 0;
        else if (a[31:28] == 4'h4) return 1;
        else return -1;
    endfunction

    function automatic int addr_target();
        if (htrans == HTRANS_NONSEQ) return dec_port(haddr);
        else if (htrans == HTRANS_IDLE) return -1;
        else return m_burst;
    endfunction

    function automatic logic exp_ready();
        if (m_err == 1) return 1'b0;
        else if (m_err == 2) return 1'b1;
        else if (m_dport >= 0) return d_hready_in[m_dport];
        else return 1'b1;
    endfunction

    function automatic logic exp_resp();
        if (m_err != 0) return 1'b1;
        else if (m_dport >= 0) return d_hresp_in[m_dport];
        else return 1'b0;
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (m_err == 0 && m_dport >= 0) return d_hrdata_in[32*m_dport +: 32];
        else return 32'h0;
    endfunction

    function automatic logic exp_exokay();
        if (m_err == 0 && m_dport >= 0) return d_hexokay_in[m_dport];
        else return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_burst = -1;
        m_dport = -1;
        m_err   = 0;
    endtask

    task automatic set_tr(input logic [1:0] tr, input logic [31:0] a);
        htrans = tr;
        haddr  = a;
    endtask

    task automatic check_model();
        int t;
        logic [3:0] et;
        @(negedge clk);
        t  = addr_target();
        et = 4'b0000;
        if (t >= 0) et[2*t +: 2] = htrans;
        chk("dst_htrans", {60'h0, o_dhtrans[0]}, {60'h0, et});
        chk("hready_resp", {63'h0, o_hready_resp[0]}, {63'h0, exp_ready()});
        chk("hresp", {63'h0, o_hresp[0]}, {63'h0, exp_resp()});
        chk("hrdata", {32'h0, o_hrdata[0]}, {32'h0, exp_rdata()});
        chk("hexokay", {63'h0, o_hexokay[0]}, {63'h0, exp_exokay()});
        chk("haddr_rep", o_dhaddr[0], {2{haddr}});
        chk("hwdata_rep", o_dhwdata[0], {2{hwdata}});
        chk("hmaster_rep", {48'h0, o_dhmaster[0]}, {48'h0, {2{hmaster}}});
        chk("hready_rep", {62'h0, o_dhready[0]}, {62'h0, {2{exp_ready()}}});
    endtask

    task automatic advance();
        logic rdy;
        int t;
        rdy = exp_ready();
        t   = addr_target();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_err == 1) begin
            m_err = 2;
        end else if (rdy) begin
            if (htrans == HTRANS_NONSEQ) m_burst = t;
            else if (htrans == HTRANS_IDLE) m_burst = -1;
            if (htrans[1] && t >= 0) begin
                m_dport = t;
                m_err   = 0;
            end else begin
                m_dport = -1;
                m_err   = htrans[1] ? 1 : 0;
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_tr(HTRANS_IDLE, 32'h0);
        hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0; hprot = 4'h3;
        hmastlock = 1'b0; hexcl = 1'b0; hmaster = 8'h5a; hwdata = 32'h0;
        d_hready_in = 2'b11; d_hresp_in = 2'b00; d_hexokay_in = 2'b00;
        d_hrdata_in = {$urandom, $urandom};
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state
        @(negedge clk);
        chk("rst_hready_resp", {63'h0, o_hready_resp[0]}, 64'h1);
        chk("rst_hresp", {63'h0, o_hresp[0]}, 64'h0);
        chk("rst_hrdata", {32'h0, o_hrdata[0]}, 64'h0);
        chk("rst_hexokay", {63'h0, o_hexokay[0]}, 64'h0);
        chk("rst_dst_htrans", {60'h0, o_dhtrans[0]}, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // INCR4 read on port 1; instance 1 overlaps, instance 2 errors throughout
        hburst = 3'b011;
        for (int b = 0; b < 6; b++) begin
            if (b == 0) set_tr(HTRANS_NONSEQ, 32'h4000_0000);
            else if (b < 4) set_tr(HTRANS_SEQ, 32'h4000_0000 + 32'(4 * b));
            else set_tr(HTRANS_IDLE, 32'h0);
            d_hrdata_in = {$urandom, $urandom};
            check_model();
            if (b < 4) chk("incr4_dst_htrans", {60'h0, o_dhtrans[0]}, {60'h0, htrans, 2'b00});
            if (b > 0 && b < 5) begin
                chk("incr4_ready", {63'h0, o_hready_resp[0]}, 64'h1);
                chk("incr4_rdata", {32'h0, o_hrdata[0]}, {32'h0, d_hrdata_in[63:32]});
            end
            if (b == 0) chk("overlap_port0", {60'h0, o_dhtrans[1]}, 64'h2);
            chk("unconn_htrans", {60'h0, o_dhtrans[2]}, 64'h0);
            if (b > 0 && b < 5) begin
                chk("unconn_ready", {63'h0, o_hready_resp[2]}, (b % 2 == 1) ? 64'h0 : 64'h1);
                chk("unconn_hresp", {63'h0, o_hresp[2]}, 64'h1);
            end
            if (b == 5) chk("unconn_recover", {62'h0, o_hready_resp[2], o_hresp[2]}, 64'h2);
            advance();
        end

        // Decode error on unmapped address
        set_tr(HTRANS_NONSEQ, 32'h8000_0000);
        check_model();
        chk("derr_dst_htrans", {60'h0, o_dhtrans[0]}, 64'h0);
        advance();
        set_tr(HTRANS_IDLE, 32'h0);
        check_model();
        chk("derr_cycle1", {62'h0, o_hready_resp[0], o_hresp[0]}, 64'h1);
        advance();
        check_model();
        chk("derr_cycle2", {62'h0, o_hready_resp[0], o_hresp[0]}, 64'h3);
        advance();
        check_model();
        chk("derr_okay", {62'h0, o_hready_resp[0], o_hresp[0]}, 64'h2);
        advance();

        // Write burst with BUSY and a 3-cycle stall on beat 2
        hwrite = 1'b1;
        set_tr(HTRANS_NONSEQ, 32'h2000_0000); hwdata = $urandom;
        check_model(); advance();
        set_tr(HTRANS_SEQ, 32'h2000_0004); hwdata = $urandom;
        check_model(); advance();
        set_tr(HTRANS_BUSY, 32'h2000_0008); hwdata = $urandom;
        d_hready_in = 2'b10; d_hexokay_in = 2'b01;
        for (int k = 0; k < 3; k++) begin
            check_model();
            chk("beat2_stall", {63'h0, o_hready_resp[0]}, 64'h0);
            chk("busy_fwd", {60'h0, o_dhtrans[0]}, 64'h1);
            advance();
        end
        d_hready_in = 2'b11;
        check_model();
        chk("beat2_done", {63'h0, o_hready_resp[0]}, 64'h1);
        chk("hexokay_pass", {63'h0, o_hexokay[0]}, 64'h1);
        advance();
        set_tr(HTRANS_SEQ, 32'h2000_0008); d_hready_in = 2'b01;
        check_model();
        chk("busy_zero_wait", {62'h0, o_hready_resp[0], o_hresp[0]}, 64'h2);
        advance();
        set_tr(HTRANS_IDLE, 32'h0); d_hready_in = 2'b11; d_hexokay_in = 2'b00;
        check_model(); advance();
        check_model(); advance();

        // Reset pulse during ERR1
        set_tr(HTRANS_NONSEQ, 32'h8000_0000);
        check_model(); advance();
        set_tr(HTRANS_IDLE, 32'h0);
        check_model();
        chk("err1_before_rst", {62'h0, o_hready_resp[0], o_hresp[0]}, 64'h1);
        #2 rst = 1'b1;
        #1 model_reset();
        chk("rst_async_resp", {62'h0, o_hready_resp[0], o_hresp[0]}, 64'h2);
        #1 rst = 1'b0;
        advance();
        check_model();
        chk("post_rst_resp", {62'h0, o_hready_resp[0], o_hresp[0]}, 64'h2);
        chk("post_rst_rdata", {32'h0, o_hrdata[0]}, 64'h0);
        advance();

        // Randomized traffic against the reference model
        acc = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (acc) begin
                htrans    = 2'($urandom_range(0, 3));
                haddr     = ({$urandom_range(0, 2)} == 32'd0) ? 32'h2000_0000 :
                            ({$urandom_range(0, 1)} == 32'd0) ? 32'h4000_0000 : 32'h8000_0000;
                haddr     = haddr | {4'h0, 26'($urandom), 2'b00};
                hwrite    = 1'($urandom);
                hsize     = 3'($urandom_range(0, 2));
                hburst    = 3'($urandom);
                hprot     = 4'($urandom);
                hmaster   = 8'($urandom);
                hwdata    = $urandom;
            end
            d_hready_in  = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
            d_hresp_in   = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            d_hexokay_in = 2'($urandom);
            d_hrdata_in  = {$urandom, $urandom};
            check_model();
            acc = exp_ready();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
